// File: rtl/ifft4.sv
// 4-point radix-2 inverse FFT. Captures four complex points, runs two butterfly
// stages, then writes the four time-domain samples out as consecutive memory beats.
module ifft4 #(
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] in_point0,
  input  logic [31:0] in_point1,
  input  logic [31:0] in_point2,
  input  logic [31:0] in_point3,
  output logic [31:0] data_out,
  output logic [31:0] address,
  output logic        we,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    STG1,
    STG2,
    OUT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;

  // Captured frequency-domain points X[0..3]
  logic signed [15:0] in_re_q [4];
  logic signed [15:0] in_re_d [4];
  logic signed [15:0] in_im_q [4];
  logic signed [15:0] in_im_d [4];

  // First-stage butterflies: index 0..3 hold a, b, c, d
  logic signed [16:0] s1_re_q [4];
  logic signed [16:0] s1_re_d [4];
  logic signed [16:0] s1_im_q [4];
  logic signed [16:0] s1_im_d [4];

  // Scaled time-domain results x[0..3]
  logic signed [15:0] y_re_q  [4];
  logic signed [15:0] y_re_d  [4];
  logic signed [15:0] y_im_q  [4];
  logic signed [15:0] y_im_d  [4];

  logic [31:0]        data_out_q, data_out_d;
  logic [31:0]        address_q, address_d;
  logic               we_q, we_d;
  logic               done_q, done_d;

  logic [31:0]        in_pt [4];

  function automatic logic signed [16:0] sx17(input logic signed [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic signed [17:0] sx18(input logic signed [16:0] v);
    return {v[16], v};
  endfunction

  // Divide by four with floor rounding; the 18-bit range guarantees the result fits 16 bits.
  function automatic logic signed [15:0] quarter(input logic signed [17:0] v);
    return 16'(v >>> 2);
  endfunction

  always_comb begin
    in_pt[0] = in_point0;
    in_pt[1] = in_point1;
    in_pt[2] = in_point2;
    in_pt[3] = in_point3;
  end

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    in_re_d    = in_re_q;
    in_im_d    = in_im_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    y_re_d     = y_re_q;
    y_im_d     = y_im_q;
    data_out_d = data_out_q;
    address_d  = address_q;
    we_d       = we_q;
    done_d     = done_q;

    unique case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (en) begin
          for (int k = 0; k < 4; k++) begin
            in_re_d[k] = in_pt[k][31:16];
            in_im_d[k] = in_pt[k][15:0];
          end
          state_d = STG1;
        end
      end

      STG1: begin
        s1_re_d[0] = sx17(in_re_q[0]) + sx17(in_re_q[2]);
        s1_im_d[0] = sx17(in_im_q[0]) + sx17(in_im_q[2]);
        s1_re_d[1] = sx17(in_re_q[0]) - sx17(in_re_q[2]);
        s1_im_d[1] = sx17(in_im_q[0]) - sx17(in_im_q[2]);
        s1_re_d[2] = sx17(in_re_q[1]) + sx17(in_re_q[3]);
        s1_im_d[2] = sx17(in_im_q[1]) + sx17(in_im_q[3]);
        s1_re_d[3] = sx17(in_re_q[1]) - sx17(in_re_q[3]);
        s1_im_d[3] = sx17(in_im_q[1]) - sx17(in_im_q[3]);
        state_d    = STG2;
      end

      STG2: begin
        // Odd outputs rotate d by +j (x1) or -j (x3) before combining with b.
        y_re_d[0] = quarter(sx18(s1_re_q[0]) + sx18(s1_re_q[2]));
        y_im_d[0] = quarter(sx18(s1_im_q[0]) + sx18(s1_im_q[2]));
        y_re_d[2] = quarter(sx18(s1_re_q[0]) - sx18(s1_re_q[2]));
        y_im_d[2] = quarter(sx18(s1_im_q[0]) - sx18(s1_im_q[2]));
        y_re_d[1] = quarter(sx18(s1_re_q[1]) - sx18(s1_im_q[3]));
        y_im_d[1] = quarter(sx18(s1_im_q[1]) + sx18(s1_re_q[3]));
        y_re_d[3] = quarter(sx18(s1_re_q[1]) + sx18(s1_im_q[3]));
        y_im_d[3] = quarter(sx18(s1_im_q[1]) - sx18(s1_re_q[3]));
        idx_d     = 2'd0;
        state_d   = OUT;
      end

      OUT: begin
        data_out_d = {y_re_q[idx_q], y_im_q[idx_q]};
        address_d  = BASE_ADDR + {30'd0, idx_q};
        we_d       = 1'b1;
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end
      end

      DONE: begin
        we_d = 1'b0;
        if (en) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the datapath registers are reset too, so a frame aborted by reset leaves no stale samples behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      data_out_q <= '0;
      address_q  <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        in_re_q[k] <= '0;
        in_im_q[k] <= '0;
        s1_re_q[k] <= '0;
        s1_im_q[k] <= '0;
        y_re_q[k]  <= '0;
        y_im_q[k]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      address_q  <= address_d;
      we_q       <= we_d;
      done_q     <= done_d;
      in_re_q    <= in_re_d;
      in_im_q    <= in_im_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      y_re_q     <= y_re_d;
      y_im_q     <= y_im_d;
    end
  end

  assign data_out = data_out_q;
  assign address  = address_q;
  assign we       = we_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ifft4.sv
// Directed bench for ifft4: two instances (base 0 and base 0x100) share stimulus;
// expected samples are hand-computed inverse transforms.
module tb_ifft4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0;

  logic [31:0] d0_data, d0_addr, d1_data, d1_addr;
  logic        d0_we, d0_done, d1_we, d1_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ifft4 dut0 (
    .clk(clk), .reset(reset), .en(en),
    .in_point0(p0), .in_point1(p1), .in_point2(p2), .in_point3(p3),
    .data_out(d0_data), .address(d0_addr), .we(d0_we), .done(d0_done)
  );

  ifft4 #(.BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .reset(reset), .en(en),
    .in_point0(p0), .in_point1(p1), .in_point2(p2), .in_point3(p3),
    .data_out(d1_data), .address(d1_addr), .we(d1_we), .done(d1_done)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Runs one transform starting from IDLE and checks every beat, the done level,
  // the no-restart hold with en high, and the done clear after en drops.
  task automatic run_frame(input string name,
                           input logic [31:0] i0, i1, i2, i3,
                           input logic [31:0] e0, e1, e2, e3,
                           input bit scramble, input bit rel_reset);
    logic [31:0] exp_s [4];
    exp_s = '{e0, e1, e2, e3};
    @(negedge clk);
    p0 = i0; p1 = i1; p2 = i2; p3 = i3;
    en = 1'b1;
    if (rel_reset) reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 3 && k <= 6) begin
        n_checks++;
        if (d0_we !== 1'b1 || d1_we !== 1'b1) begin
          n_fail++;
          $display("FAIL %s we beat%0d: got %b/%b want 1", name, k - 3, d0_we, d1_we);
        end
        n_checks++;
        if (d0_data !== exp_s[k-3] || d1_data !== exp_s[k-3]) begin
          n_fail++;
          $display("FAIL %s data x%0d: got %h/%h want %h", name, k - 3, d0_data, d1_data, exp_s[k-3]);
        end
        n_checks++;
        if (d0_addr !== 32'(k - 3)) begin
          n_fail++;
          $display("FAIL %s addr x%0d: got %h want %h", name, k - 3, d0_addr, 32'(k - 3));
        end
        n_checks++;
        if (d1_addr !== 32'h100 + 32'(k - 3)) begin
          n_fail++;
          $display("FAIL %s base addr x%0d: got %h want %h", name, k - 3, d1_addr, 32'h100 + 32'(k - 3));
        end
        n_checks++;
        if (d0_done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done early at beat%0d: got %b want 0", name, k - 3, d0_done);
        end
      end else if (k < 3) begin
        n_checks++;
        if (d0_we !== 1'b0 || d0_done !== 1'b0 || d1_we !== 1'b0) begin
          n_fail++;
          $display("FAIL %s latency k=%0d: we=%b done=%b want 0,0", name, k, d0_we, d0_done);
        end
      end else begin
        n_checks++;
        if (d0_we !== 1'b0 || d0_done !== 1'b1 || d1_done !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done: we=%b done=%b/%b want we=0 done=1", name, d0_we, d0_done, d1_done);
        end
        n_checks++;
        if (d0_data !== exp_s[3] || d0_addr !== 32'd3) begin
          n_fail++;
          $display("FAIL %s done hold: data=%h addr=%h want %h,3", name, d0_data, d0_addr, exp_s[3]);
        end
      end
      if (scramble && k < 5) begin
        p0 = $urandom; p1 = $urandom; p2 = $urandom; p3 = $urandom;
        en = k[0];
      end else begin
        en = 1'b1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (d0_we !== 1'b0 || d0_done !== 1'b1) begin
        n_fail++;
        $display("FAIL %s no restart c%0d: we=%b done=%b want 0,1", name, k, d0_we, d0_done);
      end
    end
    en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d0_done !== 1'b0 || d0_we !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done clear: done=%b we=%b want 0,0", name, d0_done, d0_we);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (d0_data !== 32'd0 || d0_addr !== 32'd0 || d0_we !== 1'b0 || d0_done !== 1'b0 ||
        d1_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset state: data=%h addr=%h we=%b done=%b want 0", d0_data, d0_addr, d0_we, d0_done);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (d0_we !== 1'b0 || d0_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle with en low: we=%b done=%b want 0,0", d0_we, d0_done);
    end
  endtask

  task automatic test_impulse();
    run_frame("impulse", 32'h0004_0000, 0, 0, 0,
              32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
  endtask

  task automatic test_tone();
    run_frame("tone", 0, 32'h0004_0000, 0, 0,
              32'h0001_0000, 32'h0000_0001, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b0);
    run_frame("dc", 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000,
              32'h0004_0000, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_extremes();
    run_frame("min", 32'h8000_8000, 32'h8000_8000, 32'h8000_8000, 32'h8000_8000,
              32'h8000_8000, 0, 0, 0, 1'b0, 1'b0);
    run_frame("max", 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h7FFF_7FFF,
              32'h7FFF_7FFF, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rounding();
    run_frame("plus1", 32'h0001_0000, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_frame("minus1", 32'hFFFF_0000, 0, 0, 0,
              32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0, 1'b0);
    run_frame("floor", 32'h0003_FFFD, 0, 0, 0,
              32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0);
  endtask

  task automatic test_input_hold();
    // X0=(8,4) X1=(4,-8) X2=(0,12) X3=(-4,0) -> x0=(2,2) x1=(4,0) x2=(2,6) x3=(0,-4)
    run_frame("hold", 32'h0008_0004, 32'h0004_FFF8, 32'h0000_000C, 32'hFFFC_0000,
              32'h0002_0002, 32'h0004_0000, 32'h0002_0006, 32'h0000_FFFC, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    p0 = 0; p1 = 32'h0004_0000; p2 = 0; p3 = 0;
    en = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (d0_we !== 1'b1 || d0_data !== 32'h0000_0001 || d0_addr !== 32'd1) begin
      n_fail++;
      $display("FAIL pre-reset x1 beat: we=%b data=%h addr=%h want 1,00000001,1", d0_we, d0_data, d0_addr);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (d0_we !== 1'b0 || d0_done !== 1'b0 || d0_data !== 32'd0 || d0_addr !== 32'd0 ||
        d1_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL async reset: we=%b done=%b data=%h addr=%h want 0", d0_we, d0_done, d0_data, d0_addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (d0_we !== 1'b0 || d0_data !== 32'd0) begin
        n_fail++;
        $display("FAIL beat during reset c%0d: we=%b data=%h want 0", k, d0_we, d0_data);
      end
    end
    run_frame("after reset", 0, 32'h0004_0000, 0, 0,
              32'h0001_0000, 32'h0000_0001, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_tone();
    test_extremes();
    test_rounding();
    test_input_hold();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
